// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage <-> M-extension sequencer bundle: request/operands in, stall and result out.
interface ex_muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            md_req;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1Data;
  logic [XLEN-1:0] rs2Data;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output md_req, func3, rs1Data, rs2Data, flush,
    input  stall, busy, result_valid, result
  );

  modport slave (
    input  md_req, func3, rs1Data, rs2Data, flush,
    output stall, busy, result_valid, result
  );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: shift-add multiply / restoring divide, one bit per cycle.
// Fixed XLEN+1 cycle latency from accept to the single result_valid cycle; stalls the front end while busy.
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  ex_muldiv_sequencer_if.slave md
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_b;      // multiplier, or dividend shifting into quotient
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_rs1_raw;
  logic              r_neg, r_dz, r_ovf;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_finish;
  logic              w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_dz, w_ovf;
  logic [XLEN:0]     w_madd;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod_s;
  logic [XLEN:0]     w_shift, w_rem_nxt;
  logic [XLEN+1:0]   w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_quo_nxt, w_b_nxt, w_q_s, w_r_s, w_res;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  assign w_accept = (r_state == S_IDLE) && md.md_req && !md.flush;
  assign w_finish = (r_state == S_BUSY) && !md.flush && (r_cnt == '0);

  // Operand signedness: MUL/MULH/DIV/REM both signed, MULHSU rs1 only, *U none.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    if (md.func3[2]) begin
      w_a_signed = !md.func3[0];
      w_b_signed = !md.func3[0];
    end else begin
      w_a_signed = (md.func3[1:0] != 2'b11);
      w_b_signed = !md.func3[1];
    end
  end

  assign w_sa    = w_a_signed & md.rs1Data[XLEN-1];
  assign w_sb    = w_b_signed & md.rs2Data[XLEN-1];
  assign w_a_mag = w_sa ? -md.rs1Data : md.rs1Data;
  assign w_b_mag = w_sb ? -md.rs2Data : md.rs2Data;
  assign w_neg   = (md.func3[2] & md.func3[1]) ? w_sa : (w_sa ^ w_sb);
  assign w_dz    = md.func3[2] && (md.rs2Data == '0);
  assign w_ovf   = md.func3[2] && !md.func3[0] && (md.rs1Data == MIN_NEG) && (&md.rs2Data);

  assign w_madd    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_acc_nxt = {w_madd, r_acc[XLEN-1:1]};

  assign w_shift   = {r_rem[XLEN-1:0], r_b[XLEN-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_a};
  assign w_ge      = !w_diff[XLEN+1];
  assign w_rem_nxt = w_ge ? w_diff[XLEN:0] : w_shift;
  assign w_quo_nxt = {r_b[XLEN-2:0], w_ge};
  assign w_b_nxt   = r_op[2] ? w_quo_nxt : {1'b0, r_b[XLEN-1:1]};

  assign w_prod_s  = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_q_s     = r_dz ? '1 : r_ovf ? MIN_NEG : (r_neg ? -w_quo_nxt : w_quo_nxt);
  assign w_r_s     = r_dz ? r_rs1_raw : r_ovf ? '0 :
                     (r_neg ? -w_rem_nxt[XLEN-1:0] : w_rem_nxt[XLEN-1:0]);

  always_comb begin
    w_res = '0;
    case (r_op)
      3'b000:         w_res = w_prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         w_res = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: w_res = w_q_s;
      default:        w_res = w_r_s;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY:  if (md.flush) w_state_nxt = S_IDLE;
               else if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_rs1_raw <= '0;
      r_neg     <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op      <= md.func3;
        r_a       <= md.func3[2] ? w_b_mag : w_a_mag;
        r_b       <= md.func3[2] ? w_a_mag : w_b_mag;
        r_acc     <= '0;
        r_rem     <= '0;
        r_rs1_raw <= md.rs1Data;
        r_neg     <= w_neg;
        r_dz      <= w_dz;
        r_ovf     <= w_ovf;
        r_cnt     <= CW'(XLEN-1);
      end else if (r_state == S_BUSY && !md.flush) begin
        r_cnt <= r_cnt - 1'b1;
        r_b   <= w_b_nxt;
        if (r_op[2]) r_rem <= w_rem_nxt;
        else         r_acc <= w_acc_nxt;
      end
      if (w_finish) r_result <= w_res;
    end
  end

  // reset gates the combinational outputs so they drop without a clock edge
  assign md.stall        = !reset && !md.flush && (w_accept || (r_state == S_BUSY));
  assign md.busy         = (r_state != S_IDLE);
  assign md.result_valid = !reset && !md.flush && (r_state == S_DONE);
  assign md.result       = r_result;
endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
Controller for a multi-cycle RV32M multiply/divide resource attached to the EX stage. It accepts one M-extension operation from EX and runs a shift-add multiply or restoring divide one bit per cycle. It stalls the front of the pipeline while busy and presents the result in a single DONE cycle, during which the EX/MEM register captures it. It sits beside the single-cycle ALU; forwarding-muxed operands feed it directly.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
md_req  input  1  EX holds a valid M-extension instruction (opcode OP, func7=0000001)
func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1Data  input  XLEN  forwarded operand A
rs2Data  input  XLEN  forwarded operand B
flush  input  1  kill the in-flight operation (branch taken / exception)
stall  output  1  freeze PC, IF/ID and ID/EX registers
busy  output  1  state != IDLE
result_valid  output  1  one-cycle pulse; result valid
result  output  XLEN  product word or quotient/remainder

Behaviour:
- States: IDLE, BUSY, DONE. Reset: state=IDLE, counter=0, result=0, result_valid=0, busy=0, internal operand/accumulator registers=0.
- Accept: IDLE && md_req && !flush. In that edge, latch func3, operand signs, and magnitudes (|x| for signed ops, raw for unsigned; MULHSU treats rs1 signed, rs2 unsigned). Clear the accumulator, set counter=XLEN-1, and go to BUSY.
- BUSY: one iteration per cycle.
  - Multiply: 2*XLEN-bit product, shift-add, LSB-first.
  - Divide: restoring, MSB-first, XLEN-bit remainder plus 1 guard bit.
  - counter decrements each cycle. When counter==0, the next state is DONE.
- DONE: result_valid=1. result shows the sign-corrected value:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Product negated if the operand signs differ (signed operand only). Quotient negated if the dividend and divisor signs differ. Remainder takes the dividend's sign.
  - DONE -> IDLE unconditionally. The op is never re-accepted even though md_req is still high in DONE.
- Latency: result_valid asserts in cycle XLEN+1 after the accept cycle (accept = cycle 0). This is fixed for all ops, including the special cases.
- Special cases (RISC-V spec), latched at accept and applied at DONE:
  - Divide by zero: quotient = all ones; remainder = dividend (unmodified).
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- stall (combinational):
  - 1 when (IDLE && md_req && !flush) or BUSY.
  - 0 in DONE, so the instruction advances with the result at that edge.
  - 0 whenever flush=1.
- result is registered, holds its value after DONE until the next DONE, and is 0 after reset. result_valid is 0 outside DONE.
- flush: from BUSY or DONE, the next state is IDLE with no result_valid pulse and result unchanged. flush in IDLE blocks acceptance. flush has priority over accept and over the counter.
- Back-to-back: a new md_req is accepted in the IDLE cycle right after DONE. Minimum spacing between accepts is XLEN+2 cycles.
- reset mid-operation: all state returns to reset values immediately (asynchronously); stall/busy/result_valid drop without waiting for a clock edge.
- func3 and operand inputs are ignored outside the accept edge.

Test Plan:
1. MUL rs1=7, rs2=6, md_req held -> stall high cycles 0..32, result_valid only in cycle 33, result=42, busy low in cycle 34.
2. MULH rs1=0xFFFFFFFE (-2), rs2=3 -> result=0xFFFFFFFF. MULHU, same operands -> result=0x00000002. MULHSU, same operands -> result=0xFFFFFFFF.
3. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> result=0x80000000. REM, same operands -> result=0. DIV rs1=-7, rs2=2 -> result=0xFFFFFFFD (-3). REM, same operands -> result=0xFFFFFFFF (-1).
4. DIVU rs1=5, rs2=0 -> result=0xFFFFFFFF. REMU, same operands -> result=5. Both take exactly 33 cycles to result_valid.
5. flush in cycle 10 of a DIVU -> stall drops in that cycle, IDLE next cycle, no result_valid, result retains its prior value. A new MUL 3*4 in the following cycle gives result=12 33 cycles later.
6. reset asserted in cycle 20 of a MUL -> busy/stall/result_valid=0 immediately, result=0. After reset deasserts, MUL 2*2 gives result=4 at cycle 33. Back-to-back MULs are accepted 34 cycles apart with no double-accept in DONE.
